// File: rtl/nco_accum.sv
// rtl/nco_accum.sv - phase accumulator NCO with staged frequency/offset registers
// Staged writes are held until a commit so increment and offset switch atomically.
module nco_accum #(
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int OFS_RST = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [3:0]       addr,
  input  logic [7:0]       data,
  output logic [OUT_W-1:0] phase,
  output logic             wrap
);

  localparam logic [31:0]      OFS_RST_V = 32'(OFS_RST);
  localparam logic [OUT_W-1:0] OFS_INIT  = OFS_RST_V[OUT_W-1:0];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] freq_stg_q, freq_stg_d;
  logic [OUT_W-1:0] ofs_q, ofs_d;
  logic [OUT_W-1:0] ofs_stg_q, ofs_stg_d;
  logic [OUT_W-1:0] phase_q, phase_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic [63:0]      freq_wide;
  logic [15:0]      ofs_wide;
  logic             commit;
  logic             clr;

  always_comb begin
    freq_stg_d = freq_stg_q;
    ofs_stg_d  = ofs_stg_q;
    inc_d      = inc_q;
    ofs_d      = ofs_q;
    acc_d      = acc_q;
    wrap_d     = 1'b0;
    freq_wide  = 64'(freq_stg_q);
    ofs_wide   = 16'(ofs_stg_q);
    sum        = {1'b0, acc_q} + {1'b0, inc_q};
    commit     = wr && (addr == 4'hF);
    clr        = commit && data[0];

    // Lanes are merged into a wide copy, then truncated so bits past the width are dropped.
    if (wr && !addr[3]) begin
      freq_wide[{addr[2:0], 3'b000} +: 8] = data;
      freq_stg_d = freq_wide[ACC_W-1:0];
    end
    if (wr && (addr[3:1] == 3'b100)) begin
      ofs_wide[{addr[0], 3'b000} +: 8] = data;
      ofs_stg_d = ofs_wide[OUT_W-1:0];
    end

    if (commit) begin
      inc_d = freq_stg_q;
      ofs_d = ofs_stg_q;
    end

    // A clearing commit beats accumulation and suppresses any carry at the same edge.
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end

    phase_d = acc_q[ACC_W-1 -: OUT_W] + ofs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      inc_q      <= '0;
      freq_stg_q <= '0;
      ofs_q      <= OFS_INIT;
      ofs_stg_q  <= OFS_INIT;
      phase_q    <= OFS_INIT;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      freq_stg_q <= freq_stg_d;
      ofs_q      <= ofs_d;
      ofs_stg_q  <= ofs_stg_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule
